stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 37 +++
 rtl/stopwatch_ctrl_edge_detect.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control block.
// Holds the FSM state enum, digit indices, default digit limits and the clamp helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ADJUST = 2'd3
    } sw_state_e;

    localparam logic [1:0] SEC_R = 2'd0;
    localparam logic [1:0] SEC_L = 2'd1;
    localparam logic [1:0] MIN_R = 2'd2;
    localparam logic [1:0] MIN_L = 2'd3;

    localparam int DEF_TENS_MAX = 5;
    localparam int DEF_ONES_MAX = 9;

    // Odd digit indices (SEC_L, MIN_L) are tens digits.
    function automatic logic [3:0] clamp_digit(input logic [1:0] sel,
                                               input logic [3:0] num,
                                               input logic [3:0] tens_max,
                                               input logic [3:0] ones_max);
        logic [3:0] lim;
        lim = sel[0] ? tens_max : ones_max;
        return (num > lim) ? lim : num;
    endfunction

    function automatic logic [3:0] onehot_sel(input logic [1:0] sel);
        logic [3:0] m;
        m = 4'b0000;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_detect.sv
// Rising-edge detector: registered history of a synchronous level, pulse when prev=0 and cur=1.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns button edges and strobes into count/clear/load pulses.
// Optional digit blinking in adjust mode is enabled with macro STOPWATCH_BLINK_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TENS_MAX = DEF_TENS_MAX,
    parameter int ONES_MAX = DEF_ONES_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_reset,
    input  logic       btn_pause,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic [3:0] num,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    output logic       count_en,
    output logic       clear,
    output logic       load_en,
    output logic [1:0] load_sel,
    output logic [3:0] load_val,
    output logic [3:0] blink_mask,
    output logic [1:0] state
);

    localparam logic [3:0] TENS_LIM = 4'(TENS_MAX);
    localparam logic [3:0] ONES_LIM = 4'(ONES_MAX);

    logic pause_edge;
    logic reset_edge;

    edge_detect u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (btn_pause),
        .rise  (pause_edge)
    );

    edge_detect u_reset_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (btn_reset),
        .rise  (reset_edge)
    );

    sw_state_e  state_q, state_d;
    logic       count_en_q, count_en_d;
    logic       clear_q, clear_d;
    logic       load_en_q, load_en_d;
    logic [1:0] load_sel_q, load_sel_d;
    logic [3:0] load_val_q, load_val_d;

    // Reset edge overrides everything; adj overrides pause edges outside ADJUST.
    always_comb begin
        state_d    = state_q;
        count_en_d = 1'b0;
        clear_d    = 1'b0;
        load_en_d  = 1'b0;
        load_sel_d = load_sel_q;
        load_val_d = load_val_q;
        if (reset_edge) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else begin
            count_en_d = (state_q == ST_RUN) && tick_1hz;
            unique case (state_q)
                ST_IDLE: begin
                    if (adj) state_d = ST_ADJUST;
                    else if (pause_edge) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (adj) state_d = ST_ADJUST;
                    else if (pause_edge) state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (adj) state_d = ST_ADJUST;
                    else if (pause_edge) state_d = ST_RUN;
                end
                ST_ADJUST: begin
                    if (!adj) state_d = ST_PAUSED;
                    if (tick_adj) begin
                        load_en_d  = 1'b1;
                        load_sel_d = sel;
                        load_val_d = clamp_digit(sel, num, TENS_LIM, ONES_LIM);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_en_q <= 1'b0;
            clear_q    <= 1'b0;
            load_en_q  <= 1'b0;
            load_sel_q <= 2'd0;
            load_val_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            count_en_q <= count_en_d;
            clear_q    <= clear_d;
            load_en_q  <= load_en_d;
            load_sel_q <= load_sel_d;
            load_val_q <= load_val_d;
        end
    end

    assign state    = state_q;
    assign count_en = count_en_q;
    assign clear    = clear_q;
    assign load_en  = load_en_q;
    assign load_sel = load_sel_q;
    assign load_val = load_val_q;

`ifdef STOPWATCH_BLINK_EN
    logic       phase_q, phase_d;
    logic [3:0] blink_mask_q, blink_mask_d;

    // Phase only survives while the FSM stays in ADJUST.
    always_comb begin
        phase_d = 1'b0;
        if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST)) begin
            phase_d = phase_q ^ tick_adj;
        end
        blink_mask_d = phase_d ? onehot_sel(sel) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            blink_mask_q <= 4'b0000;
        end else begin
            phase_q      <= phase_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    assign blink_mask = blink_mask_q;
`else
    assign blink_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed, table-driven bench for stopwatch_ctrl plus hand-written async-reset sequence.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_reset, btn_pause, adj, tick_1hz, tick_adj;
    logic [1:0] sel;
    logic [3:0] num;
    logic       count_en, clear, load_en;
    logic [1:0] load_sel, state;
    logic [3:0] load_val, blink_mask;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_reset  (btn_reset),
        .btn_pause  (btn_pause),
        .adj        (adj),
        .sel        (sel),
        .num        (num),
        .tick_1hz   (tick_1hz),
        .tick_adj   (tick_adj),
        .count_en   (count_en),
        .clear      (clear),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_val   (load_val),
        .blink_mask (blink_mask),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pau;
        logic       adj;
        logic [1:0] sel;
        logic [3:0] num;
        logic       t1;
        logic       ta;
        logic [1:0] st;
        logic       ce;
        logic       clr;
        logic       le;
        logic [1:0] ls;
        logic [3:0] lv;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int ce, input int clr,
                           input int le, input int ls, input int lv, input int mask);
        chk({tag, " state"}, int'(state), st);
        chk({tag, " count_en"}, int'(count_en), ce);
        chk({tag, " clear"}, int'(clear), clr);
        chk({tag, " load_en"}, int'(load_en), le);
        chk({tag, " load_sel"}, int'(load_sel), ls);
        chk({tag, " load_val"}, int'(load_val), lv);
        chk({tag, " blink_mask"}, int'(blink_mask), mask);
    endtask

    function automatic int blink_exp(input int m);
`ifdef STOPWATCH_BLINK_EN
        return m;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input vec_t v);
        btn_reset = v.rst;
        btn_pause = v.pau;
        adj       = v.adj;
        sel       = v.sel;
        num       = v.num;
        tick_1hz  = v.t1;
        tick_adj  = v.ta;
    endtask

    initial begin
        //          rst pau adj sel num t1 ta | st ce clr le ls lv mask
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});  // start
        vecs.push_back('{0, 0, 0, 0, 0,  1, 0,  1, 1, 0, 0, 0, 0, 0});  // tick 1
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 0,  1, 1, 0, 0, 0, 0, 0});  // tick 2
        vecs.push_back('{0, 0, 0, 0, 0,  1, 0,  1, 1, 0, 0, 0, 0, 0});  // tick 3
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  1, 0,  2, 1, 0, 0, 0, 0, 0});  // pause+tick
        vecs.push_back('{0, 0, 0, 0, 0,  1, 0,  2, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  2, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});  // resume
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 0,  1, 0,  0, 0, 1, 0, 0, 0, 0});  // reset+pause+tick
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0, 0});  // reset edge
        vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0});  // held level
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 12, 0, 0,  3, 0, 0, 0, 0, 0, 0});  // enter adjust
        vecs.push_back('{0, 0, 1, 1, 12, 0, 1,  3, 0, 0, 1, 1, 5, 2});
        vecs.push_back('{0, 0, 1, 1, 12, 0, 0,  3, 0, 0, 0, 1, 5, 2});
        vecs.push_back('{0, 0, 1, 1, 12, 0, 1,  3, 0, 0, 1, 1, 5, 0});
        vecs.push_back('{0, 0, 1, 3, 4,  0, 0,  3, 0, 0, 0, 1, 5, 0});  // hold values
        vecs.push_back('{0, 0, 1, 3, 4,  0, 1,  3, 0, 0, 1, 3, 4, 8});
        vecs.push_back('{0, 1, 1, 3, 4,  0, 0,  3, 0, 0, 0, 3, 4, 8});  // pause ignored
        vecs.push_back('{0, 0, 1, 0, 9,  0, 1,  3, 0, 0, 1, 0, 9, 0});
        vecs.push_back('{0, 0, 1, 2, 15, 0, 1,  3, 0, 0, 1, 2, 9, 4});  // ones clamp
        vecs.push_back('{0, 0, 0, 2, 15, 0, 0,  2, 0, 0, 0, 2, 9, 0});  // leave adjust
        vecs.push_back('{0, 1, 0, 2, 15, 0, 0,  1, 0, 0, 0, 2, 9, 0});
        vecs.push_back('{0, 0, 0, 2, 15, 0, 0,  1, 0, 0, 0, 2, 9, 0});
        vecs.push_back('{1, 0, 1, 2, 15, 0, 0,  0, 0, 1, 0, 2, 9, 0});  // reset beats adj
        vecs.push_back('{0, 0, 1, 2, 15, 0, 0,  3, 0, 0, 0, 2, 9, 0});
        vecs.push_back('{0, 0, 1, 2, 15, 1, 1,  3, 0, 0, 1, 2, 9, 4});
        vecs.push_back('{1, 0, 1, 2, 15, 0, 1,  0, 0, 1, 0, 2, 9, 0});  // load suppressed
        vecs.push_back('{0, 0, 0, 2, 15, 0, 0,  0, 0, 0, 0, 2, 9, 0});
        vecs.push_back('{0, 0, 0, 2, 15, 1, 0,  0, 0, 0, 0, 2, 9, 0});  // tick in IDLE
        vecs.push_back('{0, 0, 0, 2, 15, 0, 1,  0, 0, 0, 0, 2, 9, 0});

        rst_n = 1'b0;
        btn_reset = 0; btn_pause = 0; adj = 0; sel = 0; num = 0; tick_1hz = 0; tick_adj = 0;
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ce, vecs[i].clr,
                       vecs[i].le, vecs[i].ls, vecs[i].lv, blink_exp(vecs[i].mask));
        end

        // Async reset during ADJUST while a tick_adj is pending.
        @(negedge clk);
        btn_reset = 0; btn_pause = 0; adj = 1; sel = 1; num = 3; tick_1hz = 0; tick_adj = 0;
        @(posedge clk);
        #1 chk("ar enter state", int'(state), 3);
        @(negedge clk) tick_adj = 1;
        @(posedge clk);
        #1 chk("ar load_en", int'(load_en), 1);
        chk("ar load_val", int'(load_val), 3);
        @(negedge clk) tick_adj = 1;
        #1 rst_n = 1'b0;
        #1 chk_all("ar async", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_adj = 0;
        @(posedge clk);
        #1 chk_all("ar release", 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk) tick_adj = 0;
        @(posedge clk);
        #1 chk_all("ar idle", 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk) tick_adj = 1;
        @(posedge clk);
        #1 chk_all("ar next tick", 3, 0, 0, 1, 1, 3, blink_exp(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
